instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM in the RV32I core.
- Holds the program counter and drives the ROM word address combinationally.
- Registers the returned instruction and its PC into an IF/ID output register for the decoder, using a valid/ready handshake.
- Handles decoder stalls, branch/jump redirects with flush, and a halt when the PC runs past the end of program memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_WORDS, 62, number of 32-bit words in the instruction ROM; PCs at or above ROM_WORDS*4 are out of range.
- NOP_INSTR, 32'h0000_0013, instruction driven on out_instr while nothing valid is held (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  level; allows fetching to start or continue.
- rom_addr  out  32  byte address to ROM; equals pc combinationally.
- rom_data  in  32  instruction word returned combinationally by the ROM.
- redirect_valid  in  1  one-cycle pulse: taken branch or jump.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  IF/ID register holds a valid instruction.
- out_ready  in  1  decoder accepts this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  PC of out_instr.
- halted  out  1  fetch is stopped (out of range or fault).
- fetch_count  out  32  number of completed out_valid&&out_ready handshakes; wraps at 2^32.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, state=IDLE.
  - out_valid=0, out_instr=NOP_INSTR, out_pc=0.
  - halted=0, fetch_count=0.
- States:
  - IDLE: no fetch. Go to FETCH when fetch_en=1. Out-of-range check happens in FETCH only.
  - FETCH:
    - Define can_load = !out_valid || out_ready.
    - When fetch_en=1 and can_load, the edge captures out_instr=rom_data, out_pc=pc, out_valid=1, pc=pc+4 (mod 2^32).
    - When out_valid=1 and out_ready=0, out_instr, out_pc, out_valid and pc are all held stable.
    - When can_load and fetch_en=0, out_valid becomes 0 and out_instr becomes NOP_INSTR. State stays FETCH, pc is held.
    - When pc >= ROM_WORDS*4 and can_load: no capture, out_valid becomes 0, state goes to HALT, halted=1.
  - HALT: no fetch; out_valid=0; halted=1. Leaves only on a redirect (to FETCH, halted=0) or on reset.
- Redirect:
  - redirect_valid has priority over every other event, including a stall, fetch_en=0, or an out-of-range PC.
  - Same edge effects: pc=redirect_pc, out_valid=0, out_instr=NOP_INSTR; state becomes FETCH from FETCH, HALT or IDLE.
  - The instruction held in the output register is discarded and not counted, even if out_ready=1 in that cycle.
  - Latency: redirect at edge N gives the target instruction valid after edge N+1.
- Throughput: one instruction per cycle when out_ready is held at 1. First valid output appears one edge after FETCH is entered.
- fetch_count increments on each out_valid&&out_ready edge without a simultaneous redirect.
- rom_addr=pc at all times, including in IDLE and HALT; ROM reads have no side effects.
- If reset is asserted mid-operation, all state returns immediately to reset values; the in-flight instruction is lost.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - A redirect_pc with bits [1:0] != 0 loads the target but goes to HALT with halted=1 and out_valid=0.
  - Adds output misalign_fault (1 bit), set together with halted and cleared by reset or by a later aligned redirect.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 when loaded into pc; no fault port exists.

Test Plan:
- Reset, fetch_en=1, out_ready=1, ROM preloaded with the 12-word program → out_pc steps 0,4,…,44 on consecutive cycles; out_instr at out_pc=0 is 32'h00110233; fetch_count=12 after 12 handshakes.
- Hold out_ready=0 for 3 cycles while out_pc=8 → out_instr and out_pc stay stable and pc stays 12. Release out_ready → next out_pc=12, with no skip or duplicate.
- Pulse redirect_valid with redirect_pc=0x14 while out_valid=1 and out_ready=1 → next cycle out_valid=0 and fetch_count unchanged; the cycle after, out_pc=0x14.
- ROM_WORDS=4, free-run → outputs for PCs 0..12, then halted=1 and out_valid=0. A redirect to 0 resumes fetch from 0.
- Assert reset_n=0 asynchronously mid-stall → outputs reset immediately, without waiting for a clock edge.
- Redirect to 0x6:
  - Macro defined: misalign_fault=1 and halted=1.
  - Macro undefined: fetch resumes and the next out_pc=0x4.

Source files
------------

// File: rtl/instr_fetch.sv
// ============================================================================
//  Module   : instr_fetch
//  Brief    : RV32I instruction-fetch stage. Holds the PC, addresses the
//             instruction ROM combinationally and registers the returned
//             word plus its PC into a valid/ready IF/ID output register.
//             Handles decoder stalls, redirect-with-flush and end-of-memory
//             halt.
//  Options  : IF_MISALIGN_TRAP_EN - misaligned redirect targets halt fetch
//             and raise misalign_fault; otherwise bits [1:0] are cleared.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 62,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output logic [31:0] fetch_count
);

    // First byte address past the end of program memory (33 bits so that a
    // ROM_WORDS of 2^30 still compares correctly).
    localparam logic [32:0] PC_LIMIT = 33'(ROM_WORDS) << 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic        out_valid_q,   out_valid_d;
    logic [31:0] out_instr_q,   out_instr_d;
    logic [31:0] out_pc_q,      out_pc_d;
    logic        halted_q,      halted_d;
    logic [31:0] fetch_count_q, fetch_count_d;
`ifdef IF_MISALIGN_TRAP_EN
    logic        fault_q,       fault_d;
`endif

    logic w_can_load;
    logic w_handshake;
    logic w_pc_oob;

    assign w_can_load  = !out_valid_q || out_ready;
    assign w_handshake = out_valid_q && out_ready;
    assign w_pc_oob    = ({1'b0, pc_q} >= PC_LIMIT);

    // Next-state and datapath: redirect dominates, then per-state behaviour.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;
`ifdef IF_MISALIGN_TRAP_EN
        fault_d       = fault_q;
`endif

        if (redirect_valid) begin
            // Flush: the held instruction is dropped and not counted.
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            state_d     = S_FETCH;
            halted_d    = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end else begin
                fault_d  = 1'b0;
            end
`else
            pc_d = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (w_handshake) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (fetch_en) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_can_load) begin
                        if (w_pc_oob) begin
                            out_valid_d = 1'b0;
                            out_instr_d = NOP_INSTR;
                            state_d     = S_HALT;
                            halted_d    = 1'b1;
                        end else if (fetch_en) begin
                            out_valid_d = 1'b1;
                            out_instr_d = rom_data;
                            out_pc_d    = pc_q;
                            pc_d        = pc_q + 32'd4;
                        end else begin
                            out_valid_d = 1'b0;
                            out_instr_d = NOP_INSTR;
                        end
                    end
                end
                S_HALT: begin
                    out_valid_d = 1'b0;
                    halted_d    = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and IF/ID register update; asynchronous reset drops everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= NOP_INSTR;
            out_pc_q      <= 32'h0000_0000;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
`ifdef IF_MISALIGN_TRAP_EN
            fault_q       <= fault_d;
`endif
        end
    end

    assign rom_addr    = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign misalign_fault = fault_q;
`endif

endmodule

`default_nettype wire
